// File: rtl/snitch_data_mem_pkg.sv
// Shared types and the AMO lane ALU for the Snitch data memory.
package snitch_data_mem_pkg;

    typedef enum logic [3:0] {
        AMO_NONE = 4'd0,
        AMO_SWAP = 4'd1,
        AMO_ADD  = 4'd2,
        AMO_AND  = 4'd3,
        AMO_OR   = 4'd4,
        AMO_XOR  = 4'd5,
        AMO_MAX  = 4'd6,
        AMO_MAXU = 4'd7,
        AMO_MIN  = 4'd8,
        AMO_MINU = 4'd9
    } amo_op_e;

    typedef struct packed {
        logic [63:0] data;
        logic        error;
    } resp_t;

    // Opcodes above the last defined operation are reserved.
    function automatic logic amo_illegal(input logic [3:0] op);
        return op > AMO_MINU;
    endfunction

    // New lane value for an atomic read-modify-write.
    function automatic logic [31:0] amo_alu(input logic [3:0]  op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] operand);
        logic [31:0] res;
        res = old_val;
        case (op)
            AMO_SWAP: res = operand;
            AMO_ADD:  res = old_val + operand;
            AMO_AND:  res = old_val & operand;
            AMO_OR:   res = old_val | operand;
            AMO_XOR:  res = old_val ^ operand;
            AMO_MAX:  res = ($signed(old_val) > $signed(operand)) ? old_val : operand;
            AMO_MAXU: res = (old_val > operand) ? old_val : operand;
            AMO_MIN:  res = ($signed(old_val) < $signed(operand)) ? old_val : operand;
            AMO_MINU: res = (old_val < operand) ? old_val : operand;
            default:  res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/snitch_data_mem_fifo.sv
// Valid/ready FIFO used to queue memory responses; ready depends only on occupancy.
module snitch_data_mem_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [Width-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] store_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push;
    logic             pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign in_ready_o  = count_q < CntW'(Depth);
    assign out_valid_o = count_q != '0;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    // Empty queue drives zeros so the response bus is quiet when nothing is pending.
    assign out_data_o  = out_valid_o ? store_q[rd_ptr_q] : '0;

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk_i) begin
        if (push) store_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/snitch_data_mem.sv
// Single-port 64-bit data memory with loads, byte-strobed stores and 32-bit AMOs.
module snitch_data_mem #(
    parameter logic [31:0] BaseAddr  = 32'hCAFE_1000,
    parameter int unsigned Depth     = 1024,
    parameter int unsigned RespDepth = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] data_qaddr_i,
    input  logic        data_qwrite_i,
    input  logic [3:0]  data_qamo_i,
    input  logic [63:0] data_qdata_i,
    input  logic [7:0]  data_qstrb_i,
    input  logic        data_qvalid_i,
    output logic        data_qready_o,
    output logic [63:0] data_pdata_o,
    output logic        data_perror_o,
    output logic        data_pvalid_o,
    input  logic        data_pready_i
);

    import snitch_data_mem_pkg::*;

    localparam int unsigned IdxW = $clog2(Depth);

    logic [63:0]     mem_q [Depth];
    logic [31:0]     offset;
    logic            in_range;
    logic [IdxW-1:0] word_idx;
    logic            fifo_ready;
    logic            push_valid;
    logic            req_fire;
    logic [63:0]     rdata;
    logic [63:0]     wdata;
    logic            we;
    logic            is_amo;
    logic            amo_bad;
    logic            lane_sel;
    logic [31:0]     old_lane;
    logic [31:0]     opnd_lane;
    logic [31:0]     new_lane;
    resp_t           resp_d;
    resp_t           resp_q;
    logic            unused_offset;

    assign offset        = data_qaddr_i - BaseAddr;
    assign in_range      = (data_qaddr_i >= BaseAddr) && ({3'b000, offset[31:3]} < 32'(Depth));
    assign word_idx      = offset[3 +: IdxW];
    assign unused_offset = ^offset[2:0];

    // Requests seen while reset is held are neither queued nor allowed to write.
    assign push_valid    = data_qvalid_i & rst_ni;
    assign req_fire      = push_valid & fifo_ready;
    assign data_qready_o = fifo_ready;

    // Read the addressed word and run the AMO ALU on the selected 32-bit lane.
    always_comb begin
        rdata     = mem_q[word_idx];
        is_amo    = data_qamo_i != AMO_NONE;
        amo_bad   = amo_illegal(data_qamo_i);
        lane_sel  = data_qaddr_i[2];
        old_lane  = lane_sel ? rdata[63:32] : rdata[31:0];
        opnd_lane = lane_sel ? data_qdata_i[63:32] : data_qdata_i[31:0];
        new_lane  = amo_alu(data_qamo_i, old_lane, opnd_lane);
    end

    // Decode the request into a write-back word and the response it produces.
    always_comb begin
        we     = 1'b0;
        wdata  = rdata;
        resp_d = '0;
        if (!in_range || (is_amo && amo_bad)) begin
            resp_d.error = 1'b1;
        end else if (is_amo) begin
            we = 1'b1;
            if (lane_sel) begin
                wdata[63:32]       = new_lane;
                resp_d.data[63:32] = old_lane;
            end else begin
                wdata[31:0]        = new_lane;
                resp_d.data[31:0]  = old_lane;
            end
        end else if (data_qwrite_i) begin
            we = 1'b1;
            for (int unsigned b = 0; b < 8; b++) begin
                if (data_qstrb_i[b]) wdata[8*b +: 8] = data_qdata_i[8*b +: 8];
            end
        end else begin
            resp_d.data = rdata;
        end
    end

    // Memory array is never reset so its contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (req_fire && we) mem_q[word_idx] <= wdata;
    end

    snitch_data_mem_fifo #(
        .Width ($bits(resp_t)),
        .Depth (RespDepth)
    ) i_resp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_data_i   (resp_d),
        .in_valid_i  (push_valid),
        .in_ready_o  (fifo_ready),
        .out_data_o  (resp_q),
        .out_valid_o (data_pvalid_o),
        .out_ready_i (data_pready_i)
    );

    assign data_pdata_o  = resp_q.data;
    assign data_perror_o = resp_q.error;

endmodule

// File: doc/snitch_data_mem.md
SNITCH_DATA_MEM -- requirements
Module: snitch_data_mem

Interface
REQ-001 Parameter BaseAddr, default 32'hCAFE_1000, byte address of word 0.
REQ-002 Parameter Depth, default 1024, number of 64-bit words; SHALL be a power of two and at least 2.
REQ-003 Parameter RespDepth, default 2, response FIFO entries; SHALL be at least 2.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 data_qaddr_i  in  32  request byte address.
REQ-007 data_qwrite_i  in  1  1 = store, 0 = load (ignored when AMO nonzero).
REQ-008 data_qamo_i  in  4  atomic opcode, encoding per package.
REQ-009 data_qdata_i  in  64  store data / AMO operand.
REQ-010 data_qstrb_i  in  8  byte strobes for stores.
REQ-011 data_qvalid_i  in  1  request valid.
REQ-012 data_qready_o  out  1  request ready.
REQ-013 data_pdata_o  out  64  response data.
REQ-014 data_perror_o  out  1  response error.
REQ-015 data_pvalid_o  out  1  response valid.
REQ-016 data_pready_i  in  1  response ready.

Function
REQ-017 Request accepted when qvalid_i and qready_o are both high; response popped when pvalid_o and pready_i are both high.
REQ-018 qready_o SHALL be high iff the FIFO occupancy register is below RespDepth; no same-cycle pop bypass.
REQ-019 Every accepted request (load, store, AMO, error) SHALL produce exactly one response, in acceptance order.
REQ-020 Response visible on pvalid_o earliest one cycle after acceptance; back-to-back requests with pready_i held high sustain one request per cycle.
REQ-021 Word index = (qaddr_i - BaseAddr) >> 3; request in range iff qaddr_i >= BaseAddr and index < Depth; qaddr_i[1:0] ignored.
REQ-022 Load: pdata = stored word (full 64 bits), perror = 0.
REQ-023 Store: bytes with strobe set written in the acceptance cycle; pdata = 0, perror = 0.
REQ-024 AMO acts on the 32-bit lane selected by qaddr_i[2], operand from same lane of qdata_i; old lane value returned in that lane of pdata, other lane 0; new value written in acceptance cycle; strobes ignored.
REQ-025 AMO ops: 0 none, 1 SWAP, 2 ADD (mod 2^32), 3 AND, 4 OR, 5 XOR, 6 MAX signed, 7 MAXU, 8 MIN signed, 9 MINU; codes 10-15 SHALL respond perror = 1 with no write.
REQ-026 Out-of-range request SHALL respond perror = 1, pdata = 0, no memory write.
REQ-027 Request accepted and response popped in the same cycle SHALL leave occupancy unchanged.
REQ-028 A load following a store/AMO to the same word in the next cycle SHALL return the updated value.
REQ-029 pdata_o/perror_o SHALL hold stable while pvalid_o high and pready_i low.

Reset
REQ-030 While rst_ni low: FIFO empty, pvalid_o = 0, qready_o = 1, pdata_o = 0, perror_o = 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued responses; memory contents are not reset and are retained.
REQ-032 A request presented during reset SHALL not be accepted and SHALL not write.

Structure
REQ-033 Package snitch_data_mem_pkg holds the AMO opcode enum and the response entry struct {data 64, error 1}.
REQ-034 Response queue implemented as sub-module snitch_data_mem_fifo (parameterised width/depth, valid/ready both sides); AMO ALU stays combinational inside top.

Verification
REQ-035 Store 64'h1122_3344_5566_7788 strb 8'hFF to 32'hCAFE_1000, then load -> responses pdata 0, then 64'h1122_3344_5566_7788, perror 0.
REQ-036 Store 64'hFFFF_FFFF_FFFF_FFFF strb 8'h0F over zero word, load -> 64'h0000_0000_FFFF_FFFF.
REQ-037 Word lane1 = 32'h0000_0005, AMO ADD operand 3 at 32'hCAFE_1004 -> pdata 64'h0000_0005_0000_0000; subsequent load upper lane 32'h0000_0008.
REQ-038 AMO MAX signed operand 32'hFFFF_FFFF on lane value 1 -> returns 1, lane stays 1; MAXU same -> lane becomes 32'hFFFF_FFFF.
REQ-039 Load from 32'h0001_0000 and AMO opcode 12 -> both perror 1, pdata 0, memory unchanged.
REQ-040 pready_i low for 5 cycles with qvalid_i high -> exactly 2 accepted, qready_o low thereafter; release -> responses in order, no loss; rst_ni pulse with 2 queued -> pvalid_o 0 immediately, memory retained.
